// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: op encodings, FSM states, command entry.
// SEQ_WIDTH is the ALU operand width the stored command entry is built for.
package alu_seq_pkg;

   localparam int SEQ_WIDTH = 2;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_ADD = 2'b10,
      OP_SUB = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      RESP = 2'b10
   } state_e;

   typedef struct packed {
      op_e                  op;
      logic [SEQ_WIDTH-1:0] a;
      logic [SEQ_WIDTH-1:0] b;
      logic                 chain;
   } cmd_t;

   // Only the arithmetic ops report a carry/borrow; logic ops return 0.
   function automatic logic op_has_carry(input op_e op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// DEPTH x cmd_t synchronous FIFO, head visible combinationally, one-cycle push/pop.
// Push ignored when full, pop ignored when empty; count unchanged on simultaneous push+pop.
module alu_seq_fifo
   import alu_seq_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  cmd_t                     push_dat,
   input  logic                     pop,
   output cmd_t                     head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   cmd_t          mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign head_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_dat;
      end
   end

   // DEPTH is a power of two, so the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues queued {op,a,b} commands to an external 2-bit ALU; result valid 3 cycles after accept, 1 per 2 cycles.
// Stalls in RESP while res_ready is low; cmd_ready = !full. Option ALU_SEQ_CHAIN_EN feeds the previous res_y as operand a.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [WIDTH-1:0]         cmd_a,
   input  logic [WIDTH-1:0]         cmd_b,
   input  logic                     cmd_chain,
   output logic [WIDTH-1:0]         alu_a,
   output logic [WIDTH-1:0]         alu_b,
   output logic [1:0]               alu_s,
   input  logic [WIDTH-1:0]         alu_y,
   input  logic                     alu_c,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [WIDTH-1:0]         res_y,
   output logic                     res_c,
   output logic [1:0]               res_op,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count
);

   state_e           state;
   state_e           state_nxt;
   cmd_t             push_dat;
   cmd_t             head;
   logic             full;
   logic             empty;
   logic             load;
   logic             capture;
   logic [WIDTH-1:0] load_a;

   always_comb begin
      push_dat    = '0;
      push_dat.op = op_e'(cmd_op);
      push_dat.a  = cmd_a;
      push_dat.b  = cmd_b;
`ifdef ALU_SEQ_CHAIN_EN
      push_dat.chain = cmd_chain;
`else
      push_dat.chain = 1'b0;
`endif
   end

   alu_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (cmd_valid),
      .push_dat (push_dat),
      .pop      (capture),
      .head_dat (head),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

`ifdef ALU_SEQ_CHAIN_EN
   // res_y still holds the previous result whenever an entry is loaded.
   assign load_a = head.chain ? res_y : head.a;
`else
   logic chain_unused;
   assign chain_unused = cmd_chain ^ head.chain;
   assign load_a       = head.a;
`endif

   assign cmd_ready = !full;
   assign res_valid = (state == RESP);
   assign busy      = !empty || (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               load      = 1'b1;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            capture   = 1'b1;
            state_nxt = RESP;
         end
         RESP: begin
            if (res_ready) begin
               if (!empty) begin
                  load      = 1'b1;
                  state_nxt = EXEC;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_a  <= '0;
         alu_b  <= '0;
         alu_s  <= '0;
         res_y  <= '0;
         res_c  <= 1'b0;
         res_op <= '0;
      end else begin
         if (load) begin
            alu_a <= load_a;
            alu_b <= head.b;
            alu_s <= head.op;
         end
         if (capture) begin
            res_y  <= alu_y;
            res_c  <= op_has_carry(op_e'(alu_s)) ? alu_c : 1'b0;
            res_op <= alu_s;
         end
      end
   end

endmodule
